decoder_select_sequencer: RTL and testbench
===========================================

# decoder_select_sequencer

Generates the 3-bit select code that drives the 3-to-8 LED decoder stage, so the decoder shows a moving one-hot pattern instead of a hardcoded 000. The select code advances either from a debounced push-button (manual mode) or from an internal prescaled tick (auto-scan mode), counts up or down, and can be loaded directly. It sits directly upstream of the decoder: `sel` feeds the decoder's three select inputs, and `sel_valid` gates its outputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change; range 1–255.
- `SCAN_DIV`, default 8: clock cycles per auto-scan advance; range 2–65535.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `btn_step` input 1: raw push-button, asynchronous to `clk`, active-high.
- `mode_auto` input 1: synchronous; 1 selects auto-scan, 0 selects manual.
- `dir` input 1: synchronous; 0 counts up, 1 counts down.
- `load` input 1: synchronous single-cycle load strobe.
- `load_val` input 3: value written to `sel` when `load` is sampled high.
- `sel` output 3: registered select code for the decoder.
- `sel_valid` output 1: registered; high once the sequencer is running.
- `wrap` output 1: registered one-cycle pulse on a 7→0 (up) or 0→7 (down) transition.

## Operation
- FSM states: S_INIT, S_MANUAL, S_AUTO. Reset enters S_INIT.
- S_INIT:
  - Lasts exactly one clock edge after `rst_n` deasserts.
  - All inputs except `mode_auto` are ignored.
  - Transitions to S_AUTO if `mode_auto`=1, otherwise to S_MANUAL. `sel_valid` is set on the same edge.
- S_MANUAL ↔ S_AUTO follows `mode_auto` on each edge. Entering or leaving S_AUTO clears the prescaler to 0.
- Button path:
  - Two-flop synchronizer, then the debounce filter, then a rising-edge detect that produces the `step` pulse.
  - The debounce counter increments on each edge where the synchronized level differs from the debounced state, and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced state toggles and the counter clears.
  - Only a rising edge of the debounced state produces `step`. It is one cycle wide and has no auto-repeat while the button is held.
- Advance source:
  - In S_MANUAL, `step` advances `sel`.
  - In S_AUTO, `tick` advances `sel` and `step` is ignored. The debouncer keeps tracking so no stale edge fires on return to manual.
- Prescaler: counts 0..SCAN_DIV-1 in S_AUTO only; `tick` is asserted when it equals SCAN_DIV-1, and the counter returns to 0.
- Advance arithmetic: `sel` ± 1, modulo 8. On a wrap, `wrap` pulses on the same edge that `sel` updates.
- Priority: `load` > advance.
  - A load sets `sel` to `load_val`, clears the prescaler, and never pulses `wrap`.
  - An advance coincident with a load is discarded.
- `dir` is sampled on the advancing edge. A `dir` change never moves `sel` by itself.

## Timing
- Reset values: `sel`=000, `sel_valid`=0, `wrap`=0, state S_INIT, synchronizer, debounce state and prescaler at 0.
- `sel_valid` rises on the first rising edge after `rst_n` deasserts and stays high until the next reset.
- Reset assertion mid-operation clears everything immediately, independent of `clk`.
- Button latency (D = `DEBOUNCE_CYCLES`), with edge E0 the first edge that samples `btn_step` high:
  - The synchronizer output is high after E1.
  - The debounced state toggles at E(1+D).
  - `sel` updates at E(2+D).
- Glitches shorter than D synchronized samples produce no step.
- Auto latency: the first advance occurs SCAN_DIV edges after the edge that entered S_AUTO or performed a load; later advances follow every SCAN_DIV edges.
- `load` latency: `sel` = `load_val` on the edge that samples `load` high.

## Configuration
- `SEQ_DEBOUNCE_EN` defined: the debounce filter is present exactly as described above.
- Undefined:
  - The filter is removed and the debounced state equals the synchronizer output.
  - `sel` updates at E2 after the button rises.
  - `DEBOUNCE_CYCLES` is ignored.
  - All other behaviour is unchanged.

## Test plan
- Reset then release with `mode_auto`=0: `sel`=000, `sel_valid`=0 during reset; `sel_valid`=1 after the first edge, `sel` still 000.
- Macro defined, D=4, `dir`=0: press `btn_step` and hold 20 cycles from `sel`=000 → `sel`=001 exactly at E6, no further change; a 2-cycle glitch → no change.
- Up wrap: starting from 111, two steps → `sel`=000 with `wrap` high for one cycle, then 001 with `wrap` low; with `dir`=1 starting from 000 → 111 with `wrap` pulsed.
- Auto mode, SCAN_DIV=8: `sel` goes 0,1,2… every 8 cycles; button presses are ignored; returning to manual holds `sel`.
- `load`=1 with `load_val`=101 on the same edge as an auto tick → `sel`=101, no `wrap`, next advance 8 cycles later to 110.
- Assert `rst_n` mid-scan at `sel`=011 → `sel`=000, `sel_valid`=0 and `wrap`=0 immediately, without a clock edge.

Source files
------------

// File: rtl/decoder_select_sequencer.sv
// rtl/decoder_select_sequencer.sv - 3-bit select code sequencer for the LED decoder stage
// Optional button debounce filter is built when SEQ_DEBOUNCE_EN is defined.
module decoder_select_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       mode_auto,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       wrap
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_param
    $error("decoder_select_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {S_INIT, S_MANUAL, S_AUTO} state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        db_state;
  logic        db_prev;
  logic [15:0] presc;
  logic        step;
  logic        tick;
  logic        advance;
  logic [2:0]  sel_next;
  logic        wrap_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      sync1   <= btn_step;
      sync2   <= sync1;
      db_prev <= db_state;
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  logic [7:0] db_cnt;

  // The level must disagree for DEBOUNCE_CYCLES consecutive samples before it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state <= 1'b0;
      db_cnt   <= '0;
    end else if (sync2 == db_state) begin
      db_cnt <= '0;
    end else if (db_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
      db_state <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 8'd1;
    end
  end
`else
  assign db_state = sync2;
`endif

  assign step      = db_state & ~db_prev;
  assign tick      = (state == S_AUTO) && (presc == 16'(SCAN_DIV - 1));
  assign sel_next  = dir ? (sel - 3'd1) : (sel + 3'd1);
  assign wrap_next = dir ? (sel == 3'd0) : (sel == 3'd7);

  // The debouncer keeps running in auto mode; only the advance source is switched.
  always_comb begin
    advance = 1'b0;
    if (state == S_MANUAL) begin
      advance = step;
    end else if (state == S_AUTO) begin
      advance = tick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      sel       <= 3'd0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      presc     <= '0;
    end else begin
      wrap  <= 1'b0;
      state <= mode_auto ? S_AUTO : S_MANUAL;
      if (state == S_INIT) begin
        sel_valid <= 1'b1;
        presc     <= '0;
      end else begin
        if (load) begin
          sel <= load_val;
        end else if (advance) begin
          sel  <= sel_next;
          wrap <= wrap_next;
        end
        // Prescaler only runs while staying in auto; any mode change or load restarts it.
        if (load || !mode_auto || state != S_AUTO || tick) begin
          presc <= '0;
        end else begin
          presc <= presc + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// tb/tb_decoder_select_sequencer.sv - scoreboard bench for decoder_select_sequencer
module tb_decoder_select_sequencer;
  localparam int D   = 4;
  localparam int DIV = 8;
`ifdef SEQ_DEBOUNCE_EN
  localparam int PRESS_LAT    = D + 2;
  localparam int GLITCH_STEPS = 0;
`else
  localparam int PRESS_LAT    = 2;
  localparam int GLITCH_STEPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_step;
  logic       mode_auto;
  logic       dir;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] sel;
  logic       sel_valid;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state, in terms of observable behaviour.
  bit m_s1, m_s2, m_prev_level, m_valid, m_auto, m_wrap;
  int m_since, m_sel;
`ifdef SEQ_DEBOUNCE_EN
  bit m_db;
  int m_run;
`endif

  decoder_select_sequencer #(.DEBOUNCE_CYCLES(D), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .mode_auto(mode_auto),
    .dir(dir), .load(load), .load_val(load_val),
    .sel(sel), .sel_valid(sel_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev_level = 0; m_valid = 0; m_auto = 0; m_wrap = 0;
    m_since = 0; m_sel = 0;
`ifdef SEQ_DEBOUNCE_EN
    m_db = 0; m_run = 0;
`endif
  endtask

  task automatic model_edge(input bit b, input bit ma, input bit dr, input bit ld, input int lv);
    bit level;
    bit adv;
    exp_t e;
`ifdef SEQ_DEBOUNCE_EN
    level = m_db;
`else
    level = m_s2;
`endif
    if (!m_valid) begin
      m_valid = 1; m_auto = ma; m_since = 0; m_wrap = 0;
    end else begin
      adv = m_auto ? (m_since + 1 == DIV) : (level && !m_prev_level);
      m_wrap = 0;
      if (ld) begin
        m_sel = lv;
      end else if (adv) begin
        m_wrap = dr ? (m_sel == 0) : (m_sel == 7);
        m_sel  = (m_sel + (dr ? 7 : 1)) % 8;
      end
      if (ld || ma != m_auto || !m_auto || adv) m_since = 0;
      else m_since++;
      m_auto = ma;
    end
    m_prev_level = level;
`ifdef SEQ_DEBOUNCE_EN
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
`endif
    m_s2 = m_s1;
    m_s1 = b;
    e.sel = 3'(m_sel); e.valid = m_valid; e.wrap = m_wrap;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit b, input bit ma, input bit dr, input bit ld, input int lv);
    btn_step = b; mode_auto = ma; dir = dr; load = ld; load_val = 3'(lv);
    model_edge(b, ma, dr, ld, lv);
    @(negedge clk);
  endtask

  task automatic press(input bit dr);
    repeat (10) cyc(1, 0, dr, 0, 0);
    repeat (10) cyc(0, 0, dr, 0, 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sel", int'(sel), int'(mon_e.sel));
      chk("sel_valid", int'(sel_valid), int'(mon_e.valid));
      chk("wrap", int'(wrap), int'(mon_e.wrap));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int start;
    int first;
    int held;
    bit b;
    bit ma;
    model_reset();
    rst_n = 0; btn_step = 0; mode_auto = 0; dir = 0; load = 0; load_val = 0;
    repeat (3) @(negedge clk);
    chk("reset_sel", int'(sel), 0);
    chk("reset_valid", int'(sel_valid), 0);
    chk("reset_wrap", int'(wrap), 0);
    rst_n = 1;
    repeat (8) cyc(0, 0, 0, 0, 0);

    // Held press: exactly one step at the expected edge.
    cyc(0, 0, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    start = int'(sel);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (first < 0 && int'(sel) != start) first = i;
    end
    chk("press_latency", first, PRESS_LAT);
    chk("press_held", int'(sel), (start + 1) % 8);
    repeat (12) cyc(0, 0, 0, 0, 0);
    chk("release_no_step", int'(sel), (start + 1) % 8);

    start = int'(sel);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 0, 0);
    chk("glitch", int'(sel), (start + GLITCH_STEPS) % 8);

    // Wrap up from 7, then down from 0.
    cyc(0, 0, 0, 1, 7);
    press(0);
    chk("wrap_up_sel", int'(sel), 0);
    press(0);
    chk("after_wrap_sel", int'(sel), 1);
    cyc(0, 0, 1, 1, 0);
    press(1);
    chk("wrap_down_sel", int'(sel), 7);

    // Auto scan with button noise, then a load on a tick edge.
    cyc(0, 0, 0, 1, 0);
    repeat (40) cyc(1'($urandom_range(0, 1)), 1, 0, 0, 0);
    repeat (16) cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < DIV && m_since != DIV - 1; k++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 5);
    chk("load_on_tick", int'(sel), 5);
    repeat (DIV - 1) cyc(0, 1, 0, 0, 0);
    chk("after_load_hold", int'(sel), 5);
    cyc(0, 1, 0, 0, 0);
    chk("after_load_adv", int'(sel), 6);
    cyc(0, 0, 0, 0, 0);
    held = int'(sel);
    repeat (12) cyc(0, 0, 0, 0, 0);
    chk("manual_hold", int'(sel), held);

    // Randomized mix of everything.
    b = 0; ma = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) b = !b;
      if ($urandom_range(0, 59) == 0) ma = !ma;
      cyc(b, ma, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-scan at sel=3.
    cyc(0, 1, 0, 1, 0);
    for (int k = 0; k < 40 && m_sel != 3; k++) cyc(0, 1, 0, 0, 0);
    chk("pre_reset_sel", int'(sel), 3);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_sel", int'(sel), 0);
    chk("async_rst_valid", int'(sel_valid), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (30) cyc(0, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
